snes_pad_responder: RTL and testbench
=====================================

Name: snes_pad_responder

Overview:
Device-side end of the SNES joypad serial link. It presents a 12-button state to a console or host controller exactly as a physical pad would. The block samples the host's latch, oversamples the host's pad clock in the local `clk` domain, and shifts out a 16-bit active-low serial word. It sits at the FPGA pins facing the console connector and is fed by a local button source (test fixture, USB/pad bridge, or replay engine).

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers for latch_in and pad_clk_in (minimum 2).
IDLE_LEVEL, 1'b1, level driven on data_out before the first latch after reset.

Ports:
clk  input  1  system clock; must be at least 8x the pad clock rate.
res  input  1  asynchronous, active-low reset.
latch_in  input  1  host latch, active-high, asynchronous to clk.
pad_clk_in  input  1  host pad clock, idles high, asynchronous to clk.
data_out  output  1  serial button data to host, active-low (0 = pressed).
button_data  input  12  live button state, active-high. Bit order 0..11: up, down, left, right, A, B, X, Y, L, R, select, start.
frame_done  output  1  one-clk pulse when the 16th bit has been shifted out.
bit_index  output  5  number of pad-clock rising edges accepted in the current frame (0..16).

Behaviour:
- Reset (res=0, async): state=IDLE, shift register=16'hFFFF, bit_index=0, frame_done=0, data_out=IDLE_LEVEL. The synchroniser flops reset to latch=0 and pad_clk=1, so no false edge is seen on release.
- Synchroniser: latch_in and pad_clk_in each pass through SYNC_STAGES flops, then a registered edge detector. All decisions use the synchronised signals. Pin-to-response latency is SYNC_STAGES+1 clk.
- Wire order, bit 0 first: B, Y, select, start, up, down, left, right, A, X, L, R, then 1,1,1,1. Bits 12..15 are always 1 (no extension buttons).
- Encoding: wire bit = ~button_data[mapped index]. Mapping from wire 0..11 to button_data index: 5, 7, 10, 11, 0, 1, 2, 3, 4, 6, 8, 9.
- State IDLE: data_out=IDLE_LEVEL. Pad-clock edges are ignored. A synchronised latch high moves to LOAD.
- State LOAD (latch high): the shift register reloads from button_data every clk, so the last value before the latch fall wins. data_out=shift[0]. bit_index=0. Pad-clock edges are ignored. A latch falling edge moves to SHIFT.
- State SHIFT: data_out=shift[0]. On each synchronised pad-clock rising edge:
  - shift right, filling with 0;
  - bit_index+=1.
  - When bit_index reaches 16: pulse frame_done for 1 clk and move to DONE.
- State DONE: data_out=0, matching a real pad's grounded serial input. Further pad-clock edges are ignored and bit_index saturates at 16. A latch high moves to LOAD.
- Latch rising while in SHIFT (aborted frame): go to LOAD immediately, reload, set bit_index=0, and do not pulse frame_done.
- Latch edge and pad-clock edge in the same clk: the latch wins and the pad-clock edge is dropped.
- Pad-clock falling edges never change state.
- Glitches narrower than 1 clk may be missed. This is acceptable; no debounce is applied.
- Reset asserted mid-frame: immediate return to reset values. The host sees IDLE_LEVEL.

Decomposition:
- Shared package snes_pad_pkg holds:
  - PAD_WORD_BITS=16 and PAD_BUTTONS=12;
  - wire-order index constants (WIRE_B=0 … WIRE_R=11);
  - state encodings ST_IDLE/ST_LOAD/ST_SHIFT/ST_DONE;
  - the wire-to-button_data mapping table.
  The host-side controller consumes the same constants.
- Sub-module sync_edge: a SYNC_STAGES-deep synchroniser plus rise/fall pulse outputs. It has its own reset value parameter and is instantiated twice, once for latch and once for pad clock.

Test Plan:
1. Reset release with no latch, 5 pad-clock pulses -> data_out stays 1, bit_index=0, frame_done never asserts.
2. button_data=12'h020 (B only), latch pulse, 16 pad clocks -> wire bits 0111_1111_1111_1111 (first to last), frame_done is a single pulse after the 16th rising edge, then data_out=0.
3. button_data=12'h801 (start+up) -> wire bit 3=0 and bit 4=0, all other bits 1. Repeat with 12'hFFF -> wire bits 0..11 all 0 and bits 12..15 all 1.
4. button_data changes from 12'h000 to 12'h010 while latch is high, then to 12'h000 after the latch falls -> the frame shows A pressed (wire bit 8=0): last in-latch value is captured and changes after the latch are ignored.
5. Latch re-asserted after 7 pad clocks -> no frame_done, bit_index returns to 0, and the new frame restarts at B.
6. res pulled low after 9 pad clocks -> data_out=1 and bit_index=0 asynchronously. The next full latch+16-clock frame completes normally with one frame_done.

Source files
------------

// File: rtl/snes_pad_pkg.sv
// Shared SNES pad link constants: word geometry, wire order, FSM encodings
// and the wire-to-button mapping used by both ends of the link.
package snes_pad_pkg;

   localparam int unsigned PAD_WORD_BITS = 16;
   localparam int unsigned PAD_BUTTONS   = 12;
   localparam int unsigned IDX_W         = 5;

   // button_data bit positions (host-facing, active-high)
   localparam int unsigned BTN_UP     = 0;
   localparam int unsigned BTN_DOWN   = 1;
   localparam int unsigned BTN_LEFT   = 2;
   localparam int unsigned BTN_RIGHT  = 3;
   localparam int unsigned BTN_A      = 4;
   localparam int unsigned BTN_B      = 5;
   localparam int unsigned BTN_X      = 6;
   localparam int unsigned BTN_Y      = 7;
   localparam int unsigned BTN_L      = 8;
   localparam int unsigned BTN_R      = 9;
   localparam int unsigned BTN_SELECT = 10;
   localparam int unsigned BTN_START  = 11;

   // serial wire positions, bit 0 leaves first
   localparam int unsigned WIRE_B      = 0;
   localparam int unsigned WIRE_Y      = 1;
   localparam int unsigned WIRE_SELECT = 2;
   localparam int unsigned WIRE_START  = 3;
   localparam int unsigned WIRE_UP     = 4;
   localparam int unsigned WIRE_DOWN   = 5;
   localparam int unsigned WIRE_LEFT   = 6;
   localparam int unsigned WIRE_RIGHT  = 7;
   localparam int unsigned WIRE_A      = 8;
   localparam int unsigned WIRE_X      = 9;
   localparam int unsigned WIRE_L      = 10;
   localparam int unsigned WIRE_R      = 11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // wire position -> button_data index
   localparam int unsigned WIRE_MAP [PAD_BUTTONS] = '{
      BTN_B, BTN_Y, BTN_SELECT, BTN_START, BTN_UP, BTN_DOWN,
      BTN_LEFT, BTN_RIGHT, BTN_A, BTN_X, BTN_L, BTN_R
   };

   // Active-low wire word; extension bits 12..15 read as released.
   function automatic logic [PAD_WORD_BITS-1:0] encode_buttons(
      input logic [PAD_BUTTONS-1:0] btn
   );
      logic [PAD_WORD_BITS-1:0] word;
      word = '1;
      for (int unsigned w = 0; w < PAD_BUTTONS; w++) begin
         word[4'(w)] = ~btn[4'(WIRE_MAP[w])];
      end
      return word;
   endfunction

endpackage

// File: rtl/snes_pad_responder_sync_edge.sv
// Multi-stage input synchroniser with a registered previous-value edge
// detector; rise/fall pulses are one clk wide.
module sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level  = sync_q[STAGES-1];
   assign rise_c = sync_q[STAGES-1] & ~prev_q;
   assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Device side of the SNES joypad link: captures buttons while the host
// latch is high and shifts the active-low word out on pad-clock rises.
module snes_pad_responder
   import snes_pad_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        IDLE_LEVEL  = 1'b1
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   latch_in,
   input  logic                   pad_clk_in,
   output logic                   data_out,
   input  logic [PAD_BUTTONS-1:0] button_data,
   output logic                   frame_done,
   output logic [IDX_W-1:0]       bit_index
);

   localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic latch_lvl, latch_rise_c, latch_fall_c;
   logic pad_lvl, pad_rise_c, pad_fall_c;
   logic unused_sync;

   sync_edge #(.STAGES(STAGES), .RESET_VAL(1'b0)) u_latch_sync (
      .clk      (clk),
      .rst_n    (res),
      .async_in (latch_in),
      .level    (latch_lvl),
      .rise_c   (latch_rise_c),
      .fall_c   (latch_fall_c)
   );

   sync_edge #(.STAGES(STAGES), .RESET_VAL(1'b1)) u_pad_sync (
      .clk      (clk),
      .rst_n    (res),
      .async_in (pad_clk_in),
      .level    (pad_lvl),
      .rise_c   (pad_rise_c),
      .fall_c   (pad_fall_c)
   );

   // pad-clock level and falling edges carry no meaning for the device
   assign unused_sync = pad_lvl ^ pad_fall_c;

   logic [1:0]               state_q, state_d;
   logic [PAD_WORD_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
   logic                     frame_done_q, frame_done_d;
   logic                     data_out_q, data_out_d;
   logic [PAD_WORD_BITS-1:0] load_word_c;

   assign load_word_c = encode_buttons(button_data);

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      frame_done_d = 1'b0;
      data_out_d   = data_out_q;

      case (state_q)
         ST_IDLE: begin
            if (latch_lvl) begin
               state_d   = ST_LOAD;
               shift_d   = load_word_c;
               bit_idx_d = '0;
            end
         end
         ST_LOAD: begin
            // keep sampling so the last value before the latch falls wins
            shift_d   = load_word_c;
            bit_idx_d = '0;
            if (latch_fall_c) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // latch rise aborts the frame and beats a coincident pad edge
            if (latch_rise_c) begin
               state_d   = ST_LOAD;
               shift_d   = load_word_c;
               bit_idx_d = '0;
            end else if (pad_rise_c) begin
               shift_d   = {1'b0, shift_q[PAD_WORD_BITS-1:1]};
               bit_idx_d = bit_idx_q + IDX_W'(1);
               if (bit_idx_d == IDX_W'(PAD_WORD_BITS)) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (latch_lvl) begin
               state_d   = ST_LOAD;
               shift_d   = load_word_c;
               bit_idx_d = '0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            shift_d   = '1;
            bit_idx_d = '0;
         end
      endcase

      // output follows the state being entered so it is valid with it
      case (state_d)
         ST_IDLE:  data_out_d = IDLE_LEVEL;
         ST_DONE:  data_out_d = 1'b0;
         default:  data_out_d = shift_d[0];
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q      <= ST_IDLE;
         shift_q      <= '1;
         bit_idx_q    <= '0;
         frame_done_q <= 1'b0;
         data_out_q   <= IDLE_LEVEL;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         frame_done_q <= frame_done_d;
         data_out_q   <= data_out_d;
      end
   end

   assign data_out   = data_out_q;
   assign frame_done = frame_done_q;
   assign bit_index  = bit_idx_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Bench for snes_pad_responder: table of button patterns with hand-derived
// wire words, plus sequences for in-latch changes, aborts and mid-frame reset.
module tb_snes_pad_responder;

   logic        clk;
   logic        res;
   logic        latch_in;
   logic        pad_clk_in;
   logic        data_out;
   logic [11:0] button_data;
   logic        frame_done;
   logic [4:0]  bit_index;

   int n_cmp;
   int n_err;
   int fd_total;
   logic exp_q [$];

   typedef struct {
      logic [11:0] btn;
      logic [15:0] wire_word;
   } vec_t;

   vec_t vecs [8];

   snes_pad_responder #(.SYNC_STAGES(2), .IDLE_LEVEL(1'b1)) dut (
      .clk         (clk),
      .res         (res),
      .latch_in    (latch_in),
      .pad_clk_in  (pad_clk_in),
      .data_out    (data_out),
      .button_data (button_data),
      .frame_done  (frame_done),
      .bit_index   (bit_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) fd_total++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pad_pulse();
      pad_clk_in = 1'b0;
      wait_clks(4);
      pad_clk_in = 1'b1;
      wait_clks(4);
   endtask

   // latch with one button value, optionally change it after the latch falls
   task automatic do_latch(input logic [11:0] btn_in, input logic [11:0] btn_after);
      button_data = btn_in;
      latch_in = 1'b1;
      wait_clks(6);
      latch_in = 1'b0;
      wait_clks(5);
      button_data = btn_after;
   endtask

   // queue expected bits as they are driven, pop and compare at sample time
   task automatic shift_bits(input string tag, input logic [15:0] word, input int nbits);
      int fd0;
      fd0 = fd_total;
      for (int i = 0; i < nbits; i++) begin
         exp_q.push_back(word[i]);
         check($sformatf("%s bit%0d data_out", tag, i), 32'(data_out), 32'(exp_q.pop_front()));
         check($sformatf("%s bit%0d bit_index", tag, i), 32'(bit_index), 32'(i));
         if (i == 15) check($sformatf("%s early frame_done", tag), 32'(fd_total - fd0), 32'd0);
         pad_pulse();
      end
   endtask

   task automatic full_frame(input string tag, input logic [11:0] btn, input logic [15:0] word);
      int fd0;
      fd0 = fd_total;
      do_latch(btn, btn);
      shift_bits(tag, word, 16);
      check({tag, " frame_done count"}, 32'(fd_total - fd0), 32'd1);
      check({tag, " done data_out"}, 32'(data_out), 32'd0);
      check({tag, " done bit_index"}, 32'(bit_index), 32'd16);
      pad_pulse();
      check({tag, " saturated bit_index"}, 32'(bit_index), 32'd16);
      check({tag, " no extra frame_done"}, 32'(fd_total - fd0), 32'd1);
   endtask

   initial begin
      int fd0;
      n_cmp = 0;
      n_err = 0;
      fd_total = 0;

      vecs[0] = '{btn: 12'h020, wire_word: 16'hFFFE};
      vecs[1] = '{btn: 12'h801, wire_word: 16'hFFE7};
      vecs[2] = '{btn: 12'hFFF, wire_word: 16'hF000};
      vecs[3] = '{btn: 12'h000, wire_word: 16'hFFFF};
      vecs[4] = '{btn: 12'h100, wire_word: 16'hFBFF};
      vecs[5] = '{btn: 12'h0C0, wire_word: 16'hFDFD};
      vecs[6] = '{btn: 12'h20C, wire_word: 16'hF73F};
      vecs[7] = '{btn: 12'h402, wire_word: 16'hFFDB};

      res = 1'b0;
      latch_in = 1'b0;
      pad_clk_in = 1'b1;
      button_data = 12'h000;
      wait_clks(3);
      check("reset data_out", 32'(data_out), 32'd1);
      check("reset bit_index", 32'(bit_index), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      res = 1'b1;
      wait_clks(3);

      // pad clocks with no latch are ignored
      fd0 = fd_total;
      for (int i = 0; i < 5; i++) begin
         pad_pulse();
         check("idle data_out", 32'(data_out), 32'd1);
         check("idle bit_index", 32'(bit_index), 32'd0);
      end
      check("idle frame_done", 32'(fd_total - fd0), 32'd0);

      for (int v = 0; v < 8; v++) begin
         full_frame($sformatf("vec%0d", v), vecs[v].btn, vecs[v].wire_word);
      end

      // last in-latch value is captured, later changes ignored
      button_data = 12'h000;
      latch_in = 1'b1;
      wait_clks(3);
      button_data = 12'h010;
      wait_clks(4);
      latch_in = 1'b0;
      wait_clks(5);
      button_data = 12'h000;
      fd0 = fd_total;
      shift_bits("inlatch", 16'hFEFF, 16);
      check("inlatch frame_done count", 32'(fd_total - fd0), 32'd1);

      // aborted frame after 7 pad clocks
      fd0 = fd_total;
      do_latch(12'h801, 12'h801);
      shift_bits("abort", 16'hFFE7, 7);
      check("abort bit_index at 7", 32'(bit_index), 32'd7);
      latch_in = 1'b1;
      wait_clks(4);
      check("abort bit_index reloaded", 32'(bit_index), 32'd0);
      latch_in = 1'b0;
      wait_clks(5);
      check("abort no frame_done", 32'(fd_total - fd0), 32'd0);
      button_data = 12'h020;
      latch_in = 1'b1;
      wait_clks(6);
      latch_in = 1'b0;
      wait_clks(5);
      shift_bits("restart", 16'hFFFE, 16);
      check("restart frame_done count", 32'(fd_total - fd0), 32'd1);

      // asynchronous reset in the middle of a frame
      do_latch(12'hFFF, 12'hFFF);
      shift_bits("midrst", 16'hF000, 9);
      res = 1'b0;
      #1;
      check("midrst data_out", 32'(data_out), 32'd1);
      check("midrst bit_index", 32'(bit_index), 32'd0);
      wait_clks(2);
      res = 1'b1;
      wait_clks(3);
      check("post-reset data_out", 32'(data_out), 32'd1);
      full_frame("postrst", 12'h402, 16'hFFDB);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
